// File: rtl/sram_audio_streamer.sv
// PCM playback engine: reads 1- or 2-channel samples from async SRAM
// and presents one frame every CLK_DIV cycles to the DAC driver.
module sram_audio_streamer #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 16,
   parameter int NUM_CH    = 2,
   parameter int CLK_DIV   = 1042,
   parameter int READ_WAIT = 2
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic [DATA_W-1:0] SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic [DATA_W-1:0] sample_l,
   output logic [DATA_W-1:0] sample_r,
   output logic              sample_valid,
   output logic              busy,
   output logic              done
);

   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
   localparam logic [RW-1:0] R_LAST = RW'(READ_WAIT - 1);
   localparam logic [ADDR_W-1:0] N_CH = ADDR_W'(NUM_CH);

   typedef enum logic [1:0] {
      IDLE, WAIT_TICK, READ, PRESENT
   } state_t;

   state_t state, state_nx;

   logic [TW-1:0]     timer;
   logic [RW-1:0]     rw;
   logic              ch;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] words_left;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] len;
   logic              loop_q;
   logic [DATA_W-1:0] hold_l;
   logic              done_short;
   logic              tick, rd, rd_last, ch_last, go, last_word;

   assign go        = start && !stop;
   assign tick      = (state == WAIT_TICK) && !pause && (timer == T_LAST);
   assign rd        = (state == READ);
   assign rd_last   = rd && (rw == R_LAST);
   assign ch_last   = (NUM_CH == 1) || ch;
   assign last_word = (words_left == '0);

   always_ff @(posedge Clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (go && length >= N_CH) state_nx = WAIT_TICK;
         WAIT_TICK:
            if (stop)      state_nx = IDLE;
            else if (tick) state_nx = READ;
         READ:
            if (stop)                    state_nx = IDLE;
            else if (rd_last && ch_last) state_nx = PRESENT;
         PRESENT:
            if (stop || (last_word && !loop_q)) state_nx = IDLE;
            else                                state_nx = WAIT_TICK;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         timer      <= '0;
         rw         <= '0;
         ch         <= 1'b0;
         cur_addr   <= '0;
         words_left <= '0;
         base       <= '0;
         len        <= '0;
         loop_q     <= 1'b0;
         hold_l     <= '0;
         sample_l   <= '0;
         sample_r   <= '0;
         done_short <= 1'b0;
      end else begin
         done_short <= (state == IDLE) && go && (length < N_CH);
         if (state == IDLE || stop) begin
            timer <= '0;
            rw    <= '0;
            ch    <= 1'b0;
            if (state == IDLE && go) begin
               base       <= start_addr;
               len        <= length;
               loop_q     <= loop_en;
               cur_addr   <= start_addr;
               words_left <= length;
            end
         end else begin
            // timer keeps running through READ/PRESENT so frames stay evenly spaced
            if (!pause) timer <= (timer == T_LAST) ? '0 : timer + TW'(1);
            if (rd) rw <= rd_last ? '0 : rw + RW'(1);
            if (rd_last) begin
               cur_addr   <= cur_addr + ADDR_W'(1);
               words_left <= words_left - ADDR_W'(1);
               if (ch_last) begin
                  ch       <= 1'b0;
                  sample_l <= (NUM_CH == 1) ? SRAM_DQ : hold_l;
                  sample_r <= SRAM_DQ;
               end else begin
                  ch     <= 1'b1;
                  hold_l <= SRAM_DQ;
               end
            end
            if (state == PRESENT && last_word && loop_q) begin
               cur_addr   <= base;
               words_left <= len;
            end
         end
      end
   end

   assign SRAM_ADDR    = cur_addr;
   assign SRAM_CE_N    = !rd;
   assign SRAM_OE_N    = !rd;
   assign SRAM_UB_N    = !rd;
   assign SRAM_LB_N    = !rd;
   assign SRAM_WE_N    = 1'b1;
   assign sample_valid = (state == PRESENT);
   assign busy         = (state != IDLE);
   assign done         = done_short || ((state == PRESENT) && last_word);

endmodule
